// File: rtl/doa_noise_proj_calc.sv
// doa_noise_proj_calc: MUSIC denominator sum_k |a^H e_k|^2 for one steering angle.
// Streams N steering samples from ROM, accumulates per-vector projections, then squares and sums.
module doa_noise_proj_calc #(
  parameter int N               = 4,
  parameter int NVEC            = 3,
  parameter int JACOBI_WIDTH    = 32,
  parameter int DOASEARCH_WIDTH = 48,
  parameter int ROM_WIDTH       = 16,
  parameter int SHIFT           = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              calc_start_i,
  input  logic        [9:0]                 azimuth_angle_i,
  input  logic signed [JACOBI_WIDTH-1:0]    noise_vector_i [2*N*NVEC],
  output logic                              rom_rd_o,
  output logic        [10+$clog2(N)-1:0]    rom_addr_o,
  input  logic signed [ROM_WIDTH-1:0]       rom_cos_i,
  input  logic signed [ROM_WIDTH-1:0]       rom_sin_i,
  output logic        [DOASEARCH_WIDTH-1:0] calc_value_o,
  output logic                              calc_done_o,
  output logic                              busy_o
);
  localparam int MW  = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = 10 + $clog2(N);
  localparam int ACW = JACOBI_WIDTH + ROM_WIDTH + $clog2(N) + 1;
  localparam int PW  = ACW - ROM_WIDTH + 1;
  localparam int SW  = 2 * PW + $clog2(2 * NVEC) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SQUARE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [MW-1:0]              cnt_q, cnt_d, mel_q;
  logic                       vld_q;
  logic [AW-1:0]              addr_q, addr_d;
  logic [DOASEARCH_WIDTH-1:0] val_q, val_d;
  logic signed [ACW-1:0]      re_q [NVEC];
  logic signed [ACW-1:0]      re_d [NVEC];
  logic signed [ACW-1:0]      im_q [NVEC];
  logic signed [ACW-1:0]      im_d [NVEC];
  logic signed [JACOBI_WIDTH-1:0] er [NVEC];
  logic signed [JACOBI_WIDTH-1:0] ei [NVEC];
  logic signed [ACW-1:0]      c_x, s_x;
  logic signed [PW-1:0]       sr, si;
  logic signed [SW-1:0]       sum;
  logic [SW-1:0]              res;
  logic [DOASEARCH_WIDTH-1:0] sat;
  logic                       last;

  assign rom_rd_o     = state_q == FETCH;
  assign rom_addr_o   = addr_q;
  assign calc_value_o = val_q;
  assign calc_done_o  = state_q == DONE;
  assign busy_o       = state_q != IDLE;
  assign last         = cnt_q == MW'(N - 1);
  assign c_x          = ACW'(rom_cos_i);
  assign s_x          = ACW'(rom_sin_i);

  // ROM data lags the read by one cycle, so the element index travels with it in mel_q
  always_comb begin
    for (int k = 0; k < NVEC; k++) begin
      er[k] = '0;
      ei[k] = '0;
      for (int m = 0; m < N; m++) begin
        if (mel_q == MW'(m)) begin
          er[k] = noise_vector_i[2*N*k + 2*m];
          ei[k] = noise_vector_i[2*N*k + 2*m + 1];
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    sr  = '0;
    si  = '0;
    for (int k = 0; k < NVEC; k++) begin
      sr  = PW'(re_q[k] >>> (ROM_WIDTH - 1));
      si  = PW'(im_q[k] >>> (ROM_WIDTH - 1));
      sum = sum + SW'(sr) * SW'(sr) + SW'(si) * SW'(si);
    end
    res = $unsigned(sum) >> SHIFT;
    sat = (|res[SW-1:DOASEARCH_WIDTH]) ? '1 : res[DOASEARCH_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    val_d   = val_q;
    for (int k = 0; k < NVEC; k++) begin
      re_d[k] = vld_q ? re_q[k] + c_x * ACW'(er[k]) + s_x * ACW'(ei[k]) : re_q[k];
      im_d[k] = vld_q ? im_q[k] + c_x * ACW'(ei[k]) - s_x * ACW'(er[k]) : im_q[k];
    end
    case (state_q)
      IDLE: if (calc_start_i) begin
        state_d = FETCH;
        cnt_d   = '0;
        addr_d  = AW'(azimuth_angle_i) * AW'(N);
        for (int k = 0; k < NVEC; k++) begin
          re_d[k] = '0;
          im_d[k] = '0;
        end
      end
      FETCH: begin
        state_d = last ? DRAIN : FETCH;
        cnt_d   = last ? cnt_q : cnt_q + MW'(1);
        addr_d  = last ? addr_q : addr_q + AW'(1);
      end
      DRAIN:   state_d = SQUARE;
      SQUARE: begin
        state_d = DONE;
        val_d   = sat;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mel_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
      for (int k = 0; k < NVEC; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mel_q   <= cnt_q;
      vld_q   <= state_q == FETCH;
      addr_q  <= addr_d;
      val_q   <= val_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end
endmodule

// File: tb/tb_doa_noise_proj_calc.sv
// tb_doa_noise_proj_calc: table vectors plus corner sequences, checked through an expected-result scoreboard.
module tb_doa_noise_proj_calc;
  localparam int N = 4, NVEC = 3, NV = 2 * N * NVEC, AW = 12;

  logic clk = 1'b0, rst_n = 1'b0, calc_start = 1'b0;
  logic [9:0] azimuth = '0;
  logic signed [31:0] nv [NV];
  logic rom_rd, calc_done, busy;
  logic [AW-1:0] rom_addr;
  logic signed [15:0] rom_cos = '0, rom_sin = '0;
  logic [47:0] calc_value;

  int checks = 0, errors = 0, cyc = 0, rom_mode = 0;
  logic [47:0] exp_q [$];
  int cyc_q [$];
  logic [AW-1:0] addr_q [$];
  int rnd [NV];

  typedef struct {
    int az;
    int rmode;
    int nmode;
    logic [47:0] expv;
    bit use_model;
  } vec_t;
  vec_t vecs [6];

  doa_noise_proj_calc dut (
    .clk(clk), .rst_n(rst_n), .calc_start_i(calc_start), .azimuth_angle_i(azimuth),
    .noise_vector_i(nv), .rom_rd_o(rom_rd), .rom_addr_o(rom_addr),
    .rom_cos_i(rom_cos), .rom_sin_i(rom_sin), .calc_value_o(calc_value),
    .calc_done_o(calc_done), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] rc(input logic [AW-1:0] a);
    return (rom_mode == 0) ? 16'sd16384 : (rom_mode == 1) ? 16'sd32767 : 16'(int'(a) * 40503 + 12345);
  endfunction

  function automatic logic signed [15:0] rs(input logic [AW-1:0] a);
    return (rom_mode == 0) ? 16'sd0 : (rom_mode == 1) ? 16'sd32767 : 16'(int'(a) * 12011 + 777);
  endfunction

  always @(posedge clk) if (rom_rd) begin
    rom_cos <= rc(rom_addr);
    rom_sin <= rs(rom_addr);
  end

  function automatic logic [47:0] model(input int az);
    longint re [NVEC];
    longint im [NVEC];
    longint c, s, a, b;
    logic signed [127:0] r, q, sum;
    sum = '0;
    for (int k = 0; k < NVEC; k++) begin
      re[k] = 0;
      im[k] = 0;
    end
    for (int m = 0; m < N; m++) begin
      c = longint'(rc(AW'(az * N + m)));
      s = longint'(rs(AW'(az * N + m)));
      for (int k = 0; k < NVEC; k++) begin
        a = longint'(nv[k*2*N + 2*m]);
        b = longint'(nv[k*2*N + 2*m + 1]);
        re[k] += c * a + s * b;
        im[k] += c * b - s * a;
      end
    end
    for (int k = 0; k < NVEC; k++) begin
      r = re[k] >>> 15;
      q = im[k] >>> 15;
      sum += r * r + q * q;
    end
    sum = sum >>> 16;
    return (sum > 128'hFFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : sum[47:0];
  endfunction

  task automatic set_nv(input int mode);
    for (int i = 0; i < NV; i++)
      nv[i] = (mode == 0) ? 0 :
              (mode == 1) ? ((i < 2 * N && i % 2 == 0) ? 65536 : 0) :
              (mode == 2) ? 32'h7FFF_FFFF :
              (mode == 3) ? (i * 7919 + 13) * ((i % 2 != 0) ? -3 : 5) : rnd[i];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard consumer: every ROM read and every done pulse must match a pending expectation
  always @(negedge clk) begin
    if (rom_rd) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rom_rd addr %0d", rom_addr);
      end else chk("rom_addr", rom_addr, addr_q.pop_front());
    end
    if (calc_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done value %0d", calc_value);
      end else begin
        chk("calc_value", calc_value, exp_q.pop_front());
        chk("done_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
      end
    end
  end

  task automatic start(input int az, input logic [47:0] expv);
    @(negedge clk);
    calc_start = 1'b1;
    azimuth = 10'(az);
    exp_q.push_back(expv);
    cyc_q.push_back(cyc + N + 3);
    for (int m = 0; m < N; m++) addr_q.push_back(AW'(az * N + m));
    @(negedge clk);
    calc_start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic flush();
    exp_q.delete();
    cyc_q.delete();
    addr_q.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pending_done", 64'(exp_q.size()), 0);
    flush();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int dc [3];
    logic [47:0] e5;
    for (int i = 0; i < NV; i++) rnd[i] = int'($urandom_range(0, 1048575)) - 524288;
    vecs[0] = '{45,   0, 0, 48'd0,                 1'b0};
    vecs[1] = '{7,    0, 1, 48'd262144,            1'b0};
    vecs[2] = '{100,  1, 2, 48'hFFFF_FFFF_FFFF,    1'b0};
    vecs[3] = '{1023, 2, 3, 48'd0,                 1'b1};
    vecs[4] = '{300,  2, 4, 48'd0,                 1'b1};
    vecs[5] = '{0,    1, 3, 48'd0,                 1'b1};
    foreach (vecs[i]) if (vecs[i].use_model) begin
      set_nv(vecs[i].nmode);
      rom_mode = vecs[i].rmode;
      vecs[i].expv = model(vecs[i].az);
    end
    set_nv(0);
    rom_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_rom_rd", rom_rd, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_value", calc_value, 0);
    chk("rst_done", calc_done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      set_nv(vecs[i].nmode);
      rom_mode = vecs[i].rmode;
      start(vecs[i].az, vecs[i].expv);
      wait_idle();
      chk("busy_idle", busy, 0);
    end

    // Starts during the request and in the DONE cycle must be dropped
    set_nv(3);
    rom_mode = 2;
    e5 = model(5);
    start(5, e5);
    @(negedge clk);
    calc_start = 1'b1;
    azimuth = 10'd9;
    @(negedge clk);
    calc_start = 1'b0;
    n = 0;
    while (!calc_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", calc_done, 1);
    calc_start = 1'b1;
    azimuth = 10'd11;
    @(negedge clk);
    calc_start = 1'b0;
    repeat (12) @(negedge clk);
    chk("value_hold", calc_value, e5);
    chk("busy_after_ignored", busy, 0);
    chk("pending_after_ignored", 64'(exp_q.size()), 0);
    flush();

    // Asynchronous reset mid-request aborts it
    start(60, model(60));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    flush();
    #1;
    chk("abort_rom_rd", rom_rd, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_value", calc_value, 0);
    chk("abort_done", calc_done, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    start(61, model(61));
    wait_idle();

    // Back-to-back requests, each one cycle after the previous done
    set_nv(4);
    rom_mode = 2;
    start(0, model(0));
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!calc_done && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_done_seen", calc_done, 1);
      dc[i] = cyc;
      if (i < 2) start(20 * (i + 1), model(20 * (i + 1)));
    end
    chk("b2b_spacing_1", 64'(dc[1] - dc[0]), N + 4);
    chk("b2b_spacing_2", 64'(dc[2] - dc[1]), N + 4);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/doa_noise_proj_calc.md
DOA_NOISE_PROJ_CALC -- requirements
Module: doa_noise_proj_calc

Interface
REQ-001 Parameter N, default 4: array element count; complex entries per noise eigenvector.
REQ-002 Parameter NVEC, default 3: number of noise eigenvectors.
REQ-003 Parameter JACOBI_WIDTH, default 32: signed width of noise vector components.
REQ-004 Parameter DOASEARCH_WIDTH, default 48: unsigned result width.
REQ-005 Parameter ROM_WIDTH, default 16: signed Q1.(ROM_WIDTH-1) steering cos/sin width.
REQ-006 Parameter SHIFT, default 16: final right shift applied to the power sum.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 calc_start  input  1  request strobe; sampled only in IDLE.
REQ-010 azimuth_angle  input  10  requested angle, captured with calc_start.
REQ-011 noise_vector  input  JACOBI_WIDTH signed x (2*N*NVEC)  index k*2N+2m = Re(e_k,m), +1 = Im(e_k,m); stable while busy.
REQ-012 rom_rd  output  1  steering ROM read strobe.
REQ-013 rom_addr  output  10+clog2(N)  = azimuth*N + m.
REQ-014 rom_cos, rom_sin  input  ROM_WIDTH signed each  ROM data, valid exactly one cycle after rom_rd.
REQ-015 calc_value  output  DOASEARCH_WIDTH  MUSIC spectrum denominator.
REQ-016 calc_done  output  1  one-cycle completion pulse.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, FETCH, DRAIN, SQUARE, DONE; DONE always returns to IDLE next cycle.
REQ-019 IDLE: calc_start=1 -> capture azimuth, clear element counter and all 2*NVEC accumulators, go FETCH; else stay.
REQ-020 FETCH: N cycles, rom_rd=1, rom_addr for m=0..N-1 in order; go DRAIN after m=N-1 issued.
REQ-021 Each cycle ROM data is valid (FETCH cycles 2..N, DRAIN) for element m, per k: accRe_k += c*Re(e_k,m) + s*Im(e_k,m); accIm_k += c*Im(e_k,m) - s*Re(e_k,m) (p_k = a^H e_k).
REQ-022 Accumulator width JACOBI_WIDTH+ROM_WIDTH+clog2(N)+1, full signed precision, no overflow.
REQ-023 SQUARE: per k, arithmetic shift accRe_k, accIm_k right by ROM_WIDTH-1; sum = Σ_k(re^2+im^2) in full precision; result = sum >> SHIFT.
REQ-024 Result above 2^DOASEARCH_WIDTH-1 saturates to all-ones.
REQ-025 DONE: calc_value registered with result, calc_done=1 for exactly this cycle.
REQ-026 Latency: calc_start sampled at edge T -> calc_done high in cycle T+N+3 (7 cycles for N=4).
REQ-027 calc_value holds last result until next DONE; unchanged by ignored starts.
REQ-028 calc_start while busy (including DONE cycle) ignored; no queuing.
REQ-029 rom_rd=0 and rom_addr holds last value outside FETCH.
REQ-030 azimuth_angle not range-checked; address formed modulo address width.

Reset
REQ-031 rst_n low: state IDLE, calc_value=0, calc_done=0, busy=0, rom_rd=0, rom_addr=0, accumulators and counters cleared.
REQ-032 Reset mid-operation aborts the request; no calc_done produced; next start after release processed normally.

Verification
REQ-033 noise_vector all zero, start az=45 -> rom_addr 180..183, calc_done at T+7, calc_value=0.
REQ-034 ROM cos=16384, sin=0 all addresses; Re(e_0,m)=65536 all m, rest zero -> calc_value=262144 at T+7.
REQ-035 All noise components 0x7FFFFFFF, cos=sin=32767, SHIFT=0 -> calc_value saturates to 2^48-1.
REQ-036 calc_start pulsed at T+2 and in DONE cycle during request -> single calc_done, calc_value from first request only.
REQ-037 rst_n low at T+3 mid-request -> no calc_done, all outputs zero; new start -> correct result N+3 cycles later.
REQ-038 Initiator-style back-to-back: start one cycle after each done, azimuths 0,20,40 -> three pulses spaced N+4 cycles, values match software model.
